control_unit_mc: RTL
====================

CONTROL_UNIT_MC -- requirements
Module: control_unit_mc

Interface
REQ-001 Parameter XLEN, default 32, datapath/operand width in bits.
REQ-002 Parameter PC_STEP, default 4, sequential PC increment.
REQ-003 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 opcode  input  7  RV32I opcode of the current instruction.
REQ-007 rs1_data, rs2_data, imm  input  XLEN  register operands; sign-extended immediate (U-type pre-shifted).
REQ-008 alu_out  input  XLEN  result of the external ALU for alu_a/alu_b.
REQ-009 br_taken  input  1  external comparator's branch-condition result.
REQ-010 imem_ready, dmem_ready  input  1  memory-access completion strobes.
REQ-011 dmem_rdata  input  XLEN  load data, valid while dmem_ready=1.
REQ-012 imem_req, dmem_req, dmem_we  output  1  memory requests; data-memory write enable.
REQ-013 pc, dmem_addr, dmem_wdata  output  XLEN  current PC (also instruction address); data address; store data.
REQ-014 alu_a, alu_b  output  XLEN  ALU operand selects.
REQ-015 rf_wren  output  1, rf_write_data  output  XLEN  register-file write port.
REQ-016 state  output  3  current FSM state; trap  output  1  sticky misalignment flag.

Function
REQ-017 States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP.
REQ-018 FETCH: imem_req=1; stay until imem_ready=1, then DECODE; latch pc_next_seq=pc+PC_STEP (dedicated adder, modulo 2^XLEN).
REQ-019 DECODE -> EXECUTE unconditionally; no outputs active.
REQ-020 EXECUTE operands: R: rs1/rs2; OP-IMM, LOAD, STORE, JALR: rs1/imm; BRANCH, JAL, AUIPC: pc/imm; LUI: 0/imm; other: 0/0; outside EXECUTE: 0/0.
REQ-021 EXECUTE latches alu_out into alu_res and br_taken into taken_q; next MEM for LOAD/STORE, else WRITEBACK.
REQ-022 MEM: dmem_req=1, dmem_addr=alu_res, dmem_we=1 only for STORE, dmem_wdata=rs2_data; hold until dmem_ready=1, latch dmem_rdata for LOAD, then WRITEBACK.
REQ-023 WRITEBACK, single cycle: rf_wren=1 and data = alu_res (R, OP-IMM, LUI, AUIPC), load data (LOAD), pc_next_seq (JAL, JALR); rf_wren=0 otherwise and in all other states, rf_write_data=0 when rf_wren=0.
REQ-024 WRITEBACK PC update: BRANCH with taken_q=1 and JAL -> alu_res; JALR -> alu_res with bit0 cleared; all else, incl. unknown opcodes -> pc_next_seq; then FETCH.
REQ-025 imem_ready/dmem_ready outside FETCH/MEM respectively are ignored.
REQ-026 Wait states unbounded; all outputs stable while waiting.

Reset
REQ-027 rst=1 at a rising edge: state=FETCH, pc=RESET_PC, alu_res, taken_q, pc_next_seq, load data=0, trap=0.
REQ-028 Reset mid-operation (incl. MEM waiting) abandons the instruction; request deasserts the cycle after the edge and no rf/PC write occurs.
REQ-029 Reset has priority over every transition and handshake in the same cycle.

Configuration
REQ-030 Macro RV32I_CU_MISALIGN_TRAP_EN defined: in WRITEBACK, a new PC with bits[1:0]!=0 -> TRAP instead of FETCH, pc unchanged, rf_wren suppressed, trap=1; TRAP held until reset.
REQ-031 Macro undefined: no check, new PC loaded as computed, TRAP unreachable, trap tied to 0.

Verification
REQ-032 Reset, ADDI x1 (imm=5, rs1=0), imem_ready=1 immediately -> 4-cycle sequence, rf_wren=1 with data 5 in WRITEBACK, pc=0x4.
REQ-033 LOAD, dmem_ready delayed 3 cycles, dmem_rdata=0xDEADBEEF -> dmem_req held 4 cycles, rf_write_data=0xDEADBEEF, pc+=4.
REQ-034 BRANCH pc=0x100, imm=-8, br_taken=1 -> pc=0xF8; br_taken=0 -> pc=0x104, rf_wren never 1.
REQ-035 JALR pc=0x20, rs1=0x41, imm=0 -> rd data 0x24, pc=0x40.
REQ-036 STORE with rst asserted while dmem_ready=0 -> next cycle state=FETCH, pc=RESET_PC, dmem_req=0.
REQ-037 Macro defined, JAL pc=0x0, imm=0x6 -> state=TRAP, trap=1, pc=0x0, rf_wren=0; undefined -> pc=0x6.

Source files
------------

// File: rtl/control_unit_mc.sv
// Multi-cycle RV32I control unit: FETCH -> DECODE -> EXECUTE -> [MEM] -> WRITEBACK, driving an external ALU and memories.
// Define RV32I_CU_MISALIGN_TRAP_EN to trap on misaligned PCs. o_state: FETCH=0 DECODE=1 EXECUTE=2 MEM=3 WRITEBACK=4 TRAP=5.
`timescale 1ns/1ps
module control_unit_mc #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     PC_STEP  = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [6:0]      i_opcode,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic [XLEN-1:0] i_imm,
    input  logic [XLEN-1:0] i_alu_out,
    input  logic            i_br_taken,
    input  logic            i_imem_ready,
    input  logic            i_dmem_ready,
    input  logic [XLEN-1:0] i_dmem_rdata,
    output logic            o_imem_req,
    output logic            o_dmem_req,
    output logic            o_dmem_we,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_dmem_addr,
    output logic [XLEN-1:0] o_dmem_wdata,
    output logic [XLEN-1:0] o_alu_a,
    output logic [XLEN-1:0] o_alu_b,
    output logic            o_rf_wren,
    output logic [XLEN-1:0] o_rf_write_data,
    output logic [2:0]      o_state,
    output logic            o_trap
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [XLEN-1:0] PC_INC = XLEN'(PC_STEP);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pc_next_seq;
    logic [XLEN-1:0] r_alu_res;
    logic            r_taken_q;
    logic [XLEN-1:0] r_load_data;

    logic            w_seq_load;
    logic            w_exec_load;
    logic            w_ld_load;
    logic            w_pc_load;
    logic            w_is_load;
    logic            w_is_store;
    logic [XLEN-1:0] w_pc_target;

    assign w_is_load  = (i_opcode == OPC_LOAD);
    assign w_is_store = (i_opcode == OPC_STORE);

    // Redirect target chosen at WRITEBACK; unknown opcodes fall through sequentially.
    always_comb begin
        w_pc_target = r_pc_next_seq;
        case (i_opcode)
            OPC_BRANCH: w_pc_target = r_taken_q ? r_alu_res : r_pc_next_seq;
            OPC_JAL:    w_pc_target = r_alu_res;
            OPC_JALR:   w_pc_target = {r_alu_res[XLEN-1:1], 1'b0};
            default:    w_pc_target = r_pc_next_seq;
        endcase
    end

`ifdef RV32I_CU_MISALIGN_TRAP_EN
    logic r_trap;
    logic w_trap_set;
    logic w_misalign;

    assign w_misalign = (w_pc_target[1:0] != 2'b00);
    assign o_trap     = r_trap;
`else
    assign o_trap     = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-state outputs.
    always_comb begin
        w_state_nxt     = r_state;
        w_seq_load      = 1'b0;
        w_exec_load     = 1'b0;
        w_ld_load       = 1'b0;
        w_pc_load       = 1'b0;
        o_imem_req      = 1'b0;
        o_dmem_req      = 1'b0;
        o_dmem_we       = 1'b0;
        o_dmem_addr     = '0;
        o_dmem_wdata    = '0;
        o_alu_a         = '0;
        o_alu_b         = '0;
        o_rf_wren       = 1'b0;
        o_rf_write_data = '0;
`ifdef RV32I_CU_MISALIGN_TRAP_EN
        w_trap_set      = 1'b0;
`endif

        case (r_state)
            S_FETCH: begin
                o_imem_req = 1'b1;
                if (i_imem_ready) begin
                    w_seq_load  = 1'b1;
                    w_state_nxt = S_DECODE;
                end
            end

            S_DECODE: begin
                w_state_nxt = S_EXECUTE;
            end

            S_EXECUTE: begin
                w_exec_load = 1'b1;
                case (i_opcode)
                    OPC_OP: begin
                        o_alu_a = i_rs1_data;
                        o_alu_b = i_rs2_data;
                    end
                    OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_JALR: begin
                        o_alu_a = i_rs1_data;
                        o_alu_b = i_imm;
                    end
                    OPC_BRANCH, OPC_JAL, OPC_AUIPC: begin
                        o_alu_a = r_pc;
                        o_alu_b = i_imm;
                    end
                    OPC_LUI: begin
                        o_alu_b = i_imm;
                    end
                    default: ;
                endcase
                w_state_nxt = (w_is_load || w_is_store) ? S_MEM : S_WRITEBACK;
            end

            S_MEM: begin
                o_dmem_req   = 1'b1;
                o_dmem_addr  = r_alu_res;
                o_dmem_we    = w_is_store;
                o_dmem_wdata = i_rs2_data;
                if (i_dmem_ready) begin
                    w_ld_load   = w_is_load;
                    w_state_nxt = S_WRITEBACK;
                end
            end

            S_WRITEBACK: begin
`ifdef RV32I_CU_MISALIGN_TRAP_EN
                if (w_misalign) begin
                    w_trap_set  = 1'b1;
                    w_state_nxt = S_TRAP;
                end else begin
                    w_pc_load   = 1'b1;
                    w_state_nxt = S_FETCH;
                end
`else
                w_pc_load   = 1'b1;
                w_state_nxt = S_FETCH;
`endif
                case (i_opcode)
                    OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC: begin
                        o_rf_wren       = w_pc_load;
                        o_rf_write_data = w_pc_load ? r_alu_res : '0;
                    end
                    OPC_LOAD: begin
                        o_rf_wren       = w_pc_load;
                        o_rf_write_data = w_pc_load ? r_load_data : '0;
                    end
                    OPC_JAL, OPC_JALR: begin
                        o_rf_wren       = w_pc_load;
                        o_rf_write_data = w_pc_load ? r_pc_next_seq : '0;
                    end
                    default: ;
                endcase
            end

            S_TRAP: begin
                w_state_nxt = S_TRAP;
            end

            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase

        // A reset edge abandons the instruction, so the register file must not commit.
        if (i_rst) begin
            o_rf_wren       = 1'b0;
            o_rf_write_data = '0;
        end
    end

    // Datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc          <= RESET_PC;
            r_pc_next_seq <= '0;
            r_alu_res     <= '0;
            r_taken_q     <= 1'b0;
            r_load_data   <= '0;
        end else begin
            if (w_seq_load) begin
                r_pc_next_seq <= r_pc + PC_INC;
            end
            if (w_exec_load) begin
                r_alu_res <= i_alu_out;
                r_taken_q <= i_br_taken;
            end
            if (w_ld_load) begin
                r_load_data <= i_dmem_rdata;
            end
            if (w_pc_load) begin
                r_pc <= w_pc_target;
            end
        end
    end

`ifdef RV32I_CU_MISALIGN_TRAP_EN
    // Sticky trap flag, cleared only by reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_trap <= 1'b0;
        end else if (w_trap_set) begin
            r_trap <= 1'b1;
        end
    end
`endif

    assign o_pc    = r_pc;
    assign o_state = r_state;

endmodule
